// File: rtl/cp0_pkg.sv
// Shared coprocessor-0 definitions: register numbers, ExcCodes, field positions, exc_vec layout.
// Also provides the exception priority encoder used at commit.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LO  = 8;
    localparam int ST_BEV    = 22;
    localparam int CA_EXC_LO = 2;
    localparam int CA_IP_LO  = 8;
    localparam int CA_TI     = 30;
    localparam int CA_BD     = 31;

    // exc_vec = {ades, adel_data, brk, sys, ov, ri, adel_fetch}
    localparam int EV_ADEL_FETCH = 0;
    localparam int EV_RI         = 1;
    localparam int EV_OV         = 2;
    localparam int EV_SYS        = 3;
    localparam int EV_BRK        = 4;
    localparam int EV_ADEL_DATA  = 5;
    localparam int EV_ADES       = 6;
    localparam int EXC_VEC_W     = 7;

    typedef enum logic [1:0] {
        BV_NONE = 2'd0,
        BV_PC   = 2'd1,
        BV_ADDR = 2'd2
    } badv_src_t;

    typedef struct packed {
        logic      vld;
        logic [4:0] code;
        badv_src_t badv;
    } exc_sel_t;

    function automatic exc_sel_t exc_select(input logic int_req,
                                            input logic [EXC_VEC_W-1:0] ev);
        exc_sel_t s;
        s.vld  = 1'b1;
        s.code = EXC_INT;
        s.badv = BV_NONE;
        if (int_req)                s.code = EXC_INT;
        else if (ev[EV_ADEL_FETCH]) begin s.code = EXC_ADEL; s.badv = BV_PC;   end
        else if (ev[EV_RI])         s.code = EXC_RI;
        else if (ev[EV_OV])         s.code = EXC_OV;
        else if (ev[EV_SYS])        s.code = EXC_SYS;
        else if (ev[EV_BRK])        s.code = EXC_BP;
        else if (ev[EV_ADEL_DATA])  begin s.code = EXC_ADEL; s.badv = BV_ADDR; end
        else if (ev[EV_ADES])       begin s.code = EXC_ADES; s.badv = BV_ADDR; end
        else                        s.vld = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances once per COUNT_DIV cycles, TI latches on Count==Compare.
// Only built when CP0_TIMER_EN is defined; a Compare write always clears TI.
`ifdef CP0_TIMER_EN
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int DIV_W = 2;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_W'(COUNT_DIV - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt <= '0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            // A software Count write takes precedence over the increment.
            if (count_we)
                count <= wdata;
            else if (tick)
                count <= count + 32'd1;
            if (compare_we)
                compare <= wdata;
            if (compare_we)
                ti <= 1'b0;
            else if ((count == compare) && (compare != 32'd0))
                ti <= 1'b1;
        end
    end

endmodule
`endif

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file at MEM/commit: exception/interrupt arbitration, flush/redirect, MFC0/MTC0.
// Optional Count/Compare timer enabled by CP0_TIMER_EN; flush/new_pc are combinational in the commit cycle.
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter int          HW_INT_NUM = 6,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  commit_valid,
    input  logic [31:0]           commit_pc,
    input  logic                  in_delayslot,
    input  logic [6:0]            exc_vec,
    input  logic [31:0]           bad_addr,
    input  logic                  eret,
    input  logic                  mtc0_we,
    input  logic [4:0]            cp0_addr,
    input  logic [31:0]           wdata,
    input  logic [HW_INT_NUM-1:0] hw_int,
    output logic [31:0]           rdata,
    output logic                  flush,
    output logic [31:0]           new_pc,
    output logic                  int_pending
);

    logic [7:0]            st_im;
    logic                  st_exl;
    logic                  st_ie;
    logic                  cause_bd;
    logic [4:0]            cause_exc;
    logic [1:0]            ip_sw;
    logic [HW_INT_NUM-1:0] hw_q;
    logic [5:0]            ip_hw;
    logic [7:0]            ip;
    logic [31:0]           epc;
    logic [31:0]           badvaddr;
    logic [31:0]           count;
    logic [31:0]           compare;
    logic                  ti;

    logic       commit;
    exc_sel_t   sel;
    logic       exc_take;
    logic       eret_take;
    logic       mtc0_take;
    logic [31:0] status_rd;
    logic [31:0] cause_rd;

    // Holding reset also masks commit so no redirect escapes while resetn is low.
    assign commit = commit_valid & resetn;

    always_comb begin
        ip_hw = '0;
        for (int i = 0; i < HW_INT_NUM; i++)
            ip_hw[i] = hw_q[i];
    end

    assign ip          = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};
    assign int_pending = st_ie & ~st_exl & (|(ip & st_im));

    assign sel       = exc_select(int_pending, exc_vec);
    assign exc_take  = commit & sel.vld;
    assign eret_take = commit & eret & ~exc_take;
    assign mtc0_take = commit & mtc0_we & ~exc_take;

    assign flush  = exc_take | eret_take;
    assign new_pc = exc_take ? EXC_VECTOR : (eret_take ? epc : 32'h0);

    always_comb begin
        status_rd                        = '0;
        status_rd[ST_BEV]                = 1'b1;
        status_rd[ST_IM_LO +: 8]         = st_im;
        status_rd[ST_EXL]                = st_exl;
        status_rd[ST_IE]                 = st_ie;
        cause_rd                         = '0;
        cause_rd[CA_BD]                  = cause_bd;
        cause_rd[CA_TI]                  = ti;
        cause_rd[CA_IP_LO +: 8]          = ip;
        cause_rd[CA_EXC_LO +: 5]         = cause_exc;
    end

    always_comb begin
        case (cp0_addr)
            CP0_BADVADDR: rdata = badvaddr;
            CP0_COUNT:    rdata = count;
            CP0_COMPARE:  rdata = compare;
            CP0_STATUS:   rdata = status_rd;
            CP0_CAUSE:    rdata = cause_rd;
            CP0_EPC:      rdata = epc;
            default:      rdata = 32'h0;
        endcase
    end

    // Interrupt lines are level-sensitive and resampled every cycle regardless of commit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            hw_q <= '0;
        else
            hw_q <= hw_int;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_im     <= STATUS_RST[ST_IM_LO +: 8];
            st_exl    <= STATUS_RST[ST_EXL];
            st_ie     <= STATUS_RST[ST_IE];
            cause_bd  <= 1'b0;
            cause_exc <= '0;
            ip_sw     <= '0;
            epc       <= '0;
            badvaddr  <= '0;
        end else begin
            if (mtc0_take) begin
                case (cp0_addr)
                    CP0_STATUS: begin
                        st_im  <= wdata[ST_IM_LO +: 8];
                        st_exl <= wdata[ST_EXL];
                        st_ie  <= wdata[ST_IE];
                    end
                    CP0_CAUSE: ip_sw <= wdata[CA_IP_LO +: 2];
                    CP0_EPC:   epc   <= wdata;
                    default: ;
                endcase
            end
            if (eret_take)
                st_exl <= 1'b0;
            if (exc_take) begin
                // A nested exception keeps the original return point.
                if (!st_exl) begin
                    epc      <= in_delayslot ? (commit_pc - 32'd4) : commit_pc;
                    cause_bd <= in_delayslot;
                end
                st_exl    <= 1'b1;
                cause_exc <= sel.code;
                case (sel.badv)
                    BV_PC:   badvaddr <= commit_pc;
                    BV_ADDR: badvaddr <= bad_addr;
                    default: ;
                endcase
            end
        end
    end

`ifdef CP0_TIMER_EN
    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .count_we   (mtc0_take && (cp0_addr == CP0_COUNT)),
        .compare_we (mtc0_take && (cp0_addr == CP0_COMPARE)),
        .wdata      (wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );
`else
    assign count   = 32'h0;
    assign compare = 32'h0;
    assign ti      = 1'b0;
`endif

endmodule
